// File: rtl/writeback_queue_pkg.sv
// Shared constants for the writeback queue: instruction type codes and default depth.
package writeback_queue_pkg;

  localparam logic [4:0] RTYPE = 5'd1;
  localparam logic [4:0] ITYPE = 5'd2;
  localparam logic [4:0] STYPE = 5'd3;
  localparam logic [4:0] UTYPE = 5'd4;

  localparam int WB_DEPTH = 4;

  // Only these types carry a register result worth writing back.
  function automatic logic writes_reg(input logic [4:0] itype);
    return (itype == RTYPE) || (itype == ITYPE) || (itype == UTYPE);
  endfunction

endpackage

// File: rtl/writeback_queue_fifo.sv
// In-order storage for pending register writes; exposes raw entries and head for lookup.
module writeback_queue_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_data_o,
  output logic [AW-1:0] head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [W-1:0]  mem_o [DEPTH]
);

  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];

  assign full_o      = (count_q == CW'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign head_o      = head_q;
  assign count_o     = count_q;
  assign head_data_o = mem_q[head_q];
  assign mem_o       = mem_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_d   = mem_q;
    // Caller guarantees push only when not full and pop only when not empty.
    if (push_i) begin
      mem_d[tail_q] = wdata_i;
      tail_d        = tail_q + AW'(1);
    end
    if (pop_i) head_d = head_q + AW'(1);
    if (push_i && !pop_i) count_d = count_q + CW'(1);
    else if (!push_i && pop_i) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/writeback_queue.sv
// Buffers execute/memory results, drains them to the register file in order, and forwards pending values to decode.
module writeback_queue
  import writeback_queue_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int DATA_W = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              res_valid_i,
  output logic              res_ready_o,
  input  logic [DATA_W-1:0] res_data_i,
  input  logic [4:0]        res_rd_i,
  input  logic [4:0]        res_itype_i,
  output logic [DATA_W-1:0] wd_o,
  output logic [4:0]        wd_addr_o,
  output logic              wd_q_o,
  input  logic              wd_ack_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  output logic              rs1_hit_o,
  output logic [DATA_W-1:0] rs1_fwd_o,
  output logic              rs2_hit_o,
  output logic [DATA_W-1:0] rs2_fwd_o,
  output logic [CW-1:0]     count_o
);

  localparam int W = DATA_W + 5;

  logic          push, pop, full, empty;
  logic [W-1:0]  head_data;
  logic [AW-1:0] head;
  logic [CW-1:0] count;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] idx;

  assign res_ready_o = !reset && !full;
  // Filtered results still complete their handshake; they just never occupy an entry.
  assign push = res_valid_i && res_ready_o && (res_rd_i != 5'd0) && writes_reg(res_itype_i);

  assign wd_q_o    = !empty;
  assign pop       = wd_q_o && wd_ack_i;
  assign wd_addr_o = empty ? 5'd0 : head_data[W-1 -: 5];
  assign wd_o      = empty ? '0 : head_data[DATA_W-1:0];
  assign count_o   = count;

  writeback_queue_fifo #(
    .DEPTH(DEPTH),
    .W    (W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .wdata_i    ({res_rd_i, res_data_i}),
    .pop_i      (pop),
    .head_data_o(head_data),
    .head_o     (head),
    .count_o    (count),
    .full_o     (full),
    .empty_o    (empty),
    .mem_o      (mem)
  );

  // Walk oldest to youngest so a later match overwrites an earlier one.
  always_comb begin
    rs1_hit_o = 1'b0;
    rs1_fwd_o = '0;
    rs2_hit_o = 1'b0;
    rs2_fwd_o = '0;
    idx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      if (CW'(i) < count) begin
        if (rs1_i != 5'd0 && mem[idx][W-1 -: 5] == rs1_i) begin
          rs1_hit_o = 1'b1;
          rs1_fwd_o = mem[idx][DATA_W-1:0];
        end
        if (rs2_i != 5'd0 && mem[idx][W-1 -: 5] == rs2_i) begin
          rs2_hit_o = 1'b1;
          rs2_fwd_o = mem[idx][DATA_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: handshake, filter, FIFO drain, forwarding and reset flush.
module tb_writeback_queue;
  import writeback_queue_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        res_valid_i;
  logic        res_ready_o;
  logic [31:0] res_data_i;
  logic [4:0]  res_rd_i;
  logic [4:0]  res_itype_i;
  logic [31:0] wd_o;
  logic [4:0]  wd_addr_o;
  logic        wd_q_o;
  logic        wd_ack_i;
  logic [4:0]  rs1_i, rs2_i;
  logic        rs1_hit_o, rs2_hit_o;
  logic [31:0] rs1_fwd_o, rs2_fwd_o;
  logic [2:0]  count_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  writeback_queue #(.DEPTH(4), .DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .res_valid_i(res_valid_i),
    .res_ready_o(res_ready_o),
    .res_data_i (res_data_i),
    .res_rd_i   (res_rd_i),
    .res_itype_i(res_itype_i),
    .wd_o       (wd_o),
    .wd_addr_o  (wd_addr_o),
    .wd_q_o     (wd_q_o),
    .wd_ack_i   (wd_ack_i),
    .rs1_i      (rs1_i),
    .rs2_i      (rs2_i),
    .rs1_hit_o  (rs1_hit_o),
    .rs1_fwd_o  (rs1_fwd_o),
    .rs2_hit_o  (rs2_hit_o),
    .rs2_fwd_o  (rs2_fwd_o),
    .count_o    (count_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic offer(input logic [4:0] rd, input logic [31:0] data, input logic [4:0] it);
    res_valid_i = 1'b1;
    res_rd_i    = rd;
    res_data_i  = data;
    res_itype_i = it;
  endtask

  initial begin
    reset = 1'b1; res_valid_i = 1'b0; res_data_i = '0; res_rd_i = '0;
    res_itype_i = '0; wd_ack_i = 1'b0; rs1_i = '0; rs2_i = '0;
    step();
    chk("ready_in_reset", res_ready_o, 1'b0);
    step();
    reset = 1'b0;
    step();
    chk("rst_ready", res_ready_o, 1'b1);
    chk("rst_wdq", wd_q_o, 1'b0);
    chk("rst_count", count_o, 3'd0);
    chk("rst_wd", wd_o, 32'd0);
    chk("rst_hit1", rs1_hit_o, 1'b0);
    chk("rst_hit2", rs2_hit_o, 1'b0);

    // single result, immediate ack
    wd_ack_i = 1'b1;
    offer(5'd5, 32'hDEADBEEF, RTYPE);
    step();
    res_valid_i = 1'b0;
    chk("single_wdq", wd_q_o, 1'b1);
    chk("single_addr", wd_addr_o, 5'd5);
    chk("single_data", wd_o, 32'hDEADBEEF);
    step();
    chk("single_wdq_after", wd_q_o, 1'b0);
    chk("single_count_after", count_o, 3'd0);
    chk("single_addr_after", wd_addr_o, 5'd0);

    // filtered results complete but are dropped
    offer(5'd0, 32'h1234, ITYPE);
    chk("filt0_ready", res_ready_o, 1'b1);
    step();
    chk("filt0_count", count_o, 3'd0);
    chk("filt0_wdq", wd_q_o, 1'b0);
    offer(5'd9, 32'h55, STYPE);
    chk("filt_st_ready", res_ready_o, 1'b1);
    step();
    chk("filt_st_count", count_o, 3'd0);
    chk("filt_st_wdq", wd_q_o, 1'b0);
    offer(5'd3, 32'h77, 5'd31);
    step();
    chk("filt_bad_count", count_o, 3'd0);
    chk("filt_bad_wdq", wd_q_o, 1'b0);
    res_valid_i = 1'b0;

    // fill, hold a fifth, then drain
    wd_ack_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      offer(5'(i), 32'(i * 16), ITYPE);
      step();
    end
    chk("full_count", count_o, 3'd4);
    chk("full_ready", res_ready_o, 1'b0);
    offer(5'd6, 32'h60, UTYPE);
    step();
    chk("held_count", count_o, 3'd4);
    chk("held_head", wd_addr_o, 5'd1);
    wd_ack_i = 1'b1;
    chk("full_pop_ready", res_ready_o, 1'b0);
    step();
    chk("drain1_count", count_o, 3'd3);
    chk("drain1_addr", wd_addr_o, 5'd2);
    chk("drain1_data", wd_o, 32'h20);
    chk("drain1_ready", res_ready_o, 1'b1);
    step();
    res_valid_i = 1'b0;
    chk("drain2_count", count_o, 3'd3);
    chk("drain2_addr", wd_addr_o, 5'd3);
    step();
    chk("drain3_count", count_o, 3'd2);
    chk("drain3_addr", wd_addr_o, 5'd4);
    chk("drain3_data", wd_o, 32'h40);
    step();
    chk("drain4_count", count_o, 3'd1);
    chk("drain4_addr", wd_addr_o, 5'd6);
    chk("drain4_data", wd_o, 32'h60);
    step();
    chk("drain_empty_wdq", wd_q_o, 1'b0);
    chk("drain_empty_count", count_o, 3'd0);

    // forwarding picks the youngest match; incoming data is invisible
    wd_ack_i = 1'b0;
    rs1_i = 5'd7;
    rs2_i = 5'd0;
    offer(5'd7, 32'h11, RTYPE);
    step();
    offer(5'd7, 32'h22, RTYPE);
    chk("fwd_one_hit", rs1_hit_o, 1'b1);
    chk("fwd_one_val", rs1_fwd_o, 32'h11);
    step();
    res_valid_i = 1'b0;
    chk("fwd_hit1", rs1_hit_o, 1'b1);
    chk("fwd_val1", rs1_fwd_o, 32'h22);
    chk("fwd_hit2_r0", rs2_hit_o, 1'b0);
    chk("fwd_val2_r0", rs2_fwd_o, 32'h0);
    rs2_i = 5'd8;
    chk("fwd_hit2_miss", rs2_hit_o, 1'b0);
    wd_ack_i = 1'b1;
    chk("fwd_popping_hit", rs1_hit_o, 1'b1);
    step();
    wd_ack_i = 1'b0;
    chk("fwd_pop1_hit", rs1_hit_o, 1'b1);
    chk("fwd_pop1_val", rs1_fwd_o, 32'h22);
    chk("fwd_pop1_count", count_o, 3'd1);
    wd_ack_i = 1'b1;
    step();
    wd_ack_i = 1'b0;
    chk("fwd_pop2_hit", rs1_hit_o, 1'b0);
    chk("fwd_pop2_val", rs1_fwd_o, 32'h0);
    chk("fwd_pop2_count", count_o, 3'd0);

    // reset flushes queued entries without writing them
    for (int i = 10; i <= 12; i++) begin
      offer(5'(i), 32'(i), RTYPE);
      step();
    end
    res_valid_i = 1'b0;
    chk("flush_pre_count", count_o, 3'd3);
    wd_ack_i = 1'b1;
    reset = 1'b1;
    step();
    chk("flush_ready", res_ready_o, 1'b0);
    chk("flush_count", count_o, 3'd0);
    chk("flush_wdq", wd_q_o, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("flush_post_wdq", wd_q_o, 1'b0);
    end
    chk("flush_post_count", count_o, 3'd0);
    chk("flush_post_ready", res_ready_o, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
